interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
Multi-source interrupt controller that sequences the program counter's interrupt entry (intr) and return (reti) controls. It latches requests from NUM_SRC peripherals, applies a per-source mask and a global enable, and picks one source by fixed priority. It only redirects the PC at an instruction boundary, never in a cycle with a pending jump. It enforces a single level of service, matching the PC's single saved-return-address register.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..15)
VEC_BASE, 16'h0002, handler address of source 0
VEC_STRIDE, 16'h0002, address spacing between consecutive source handlers

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
irq  input  NUM_SRC  request lines from peripherals; bit 0 has highest priority
cfgWe  input  1  write strobe for the configuration register
cfgData  input  NUM_SRC+1  bits [NUM_SRC-1:0] = mask (1 = enabled); bit NUM_SRC = gie
instrDone  input  1  current instruction retires this cycle, so the PC may be redirected
jmpPending  input  1  absJmp or relJmp is asserted to the PC this cycle
retiIn  input  1  decoder has decoded a RETI instruction
intrOut  output  1  one-cycle pulse driving the PC's intr input
retiOut  output  1  one-cycle pulse driving the PC's reti input
vecAddr  output  16  handler address; valid while intrOut=1, held until the next entry
activeId  output  4  id of the source in service; holds the last value otherwise
busy  output  1  high in ENTER and SERVICE
ack  output  NUM_SRC  one-hot, one-cycle acknowledge to the selected peripheral
cfgOut  output  NUM_SRC+1  readback of {gie, mask}

Behaviour:
- Reset (asynchronous): state=IDLE; mask=0; gie=0; pending=0; irqPrev=0; holdoff=0. All outputs 0, vecAddr=0, activeId=0. Because irqPrev resets to 0, an irq line already high when reset releases counts as a rising edge.
- Reset mid-operation (ENTER/SERVICE/EXIT) returns to IDLE immediately. No retiOut is issued; any pending ack is dropped.
- Pending latch: pending[i] is set on a rising edge of irq[i] (irq & ~irqPrev). It is cleared only when source i is accepted. If a set and a clear hit the same bit in the same cycle, the set wins.
- Config: on cfgWe, {gie, mask} <= cfgData at the clock edge. The accept decision in that same cycle uses the old values.
- Selection: cand = pending & mask. id = lowest set index of cand.
- accept = (state==IDLE) & gie & (cand!=0) & instrDone & ~jmpPending & ~holdoff.
- FSM, IDLE -> ENTER: on accept. Register id into activeId. vecAddr <= VEC_BASE + id*VEC_STRIDE, 16-bit wrap-around. Clear pending[id].
- FSM, ENTER: intrOut=1 and ack[id]=1 for exactly one cycle, then go to SERVICE.
- FSM, SERVICE: irqs keep latching but nothing is accepted. retiIn=1 moves to EXIT.
- FSM, EXIT: retiOut=1 for one cycle, then go to IDLE with holdoff=1.
- Latency: accept to intrOut is 1 cycle; retiIn to retiOut is 1 cycle. The decoder must hold instrDone low during that one cycle.
- holdoff: cleared by the first instrDone=1 seen in IDLE. This guarantees at least one interrupted-program instruction executes between back-to-back interrupts. Accept is blocked during the holdoff cycle itself.
- retiIn outside SERVICE is ignored: no retiOut, no state change.
- jmpPending=1 while accept conditions otherwise hold defers entry to the next eligible cycle. Pending is not lost.
- Clearing gie or mask while in SERVICE does not abort service; it only affects later accepts.

Optional Feature:
Macro INTC_LEVEL_EN.
- Defined: sources are level-sensitive. pending = irq (no latch, irqPrev unused). A source must hold irq until ack, and must deassert it before retiOut or it is re-taken after holdoff.
- Undefined: edge-latched behaviour as specified above.

Test Plan:
- Reset release with irq=4'b0000, then cfgWe with cfgData=5'b11111, irq[2] rising, instrDone=1 -> intrOut pulse 1 cycle later, vecAddr=16'h0006, activeId=2, ack=4'b0100, busy=1.
- irq[3] and irq[1] rise in the same cycle with all enabled -> source 1 taken first (vecAddr=16'h0004). After retiIn, retiOut, then one instrDone, source 3 is taken (vecAddr=16'h0008).
- Accept conditions met with jmpPending=1 for 3 cycles -> no intrOut during those cycles. intrOut asserts 1 cycle after jmpPending falls with instrDone=1.
- mask=4'b1110, irq[0] edge -> no entry. Then cfgWe sets mask=4'b1111 -> entry for source 0 (vecAddr=16'h0002) on the next eligible instrDone.
- In SERVICE, irq[0] edge arrives, then retiIn -> retiOut pulses once. No intrOut in the holdoff cycle; source 0 is taken after the next instrDone.
- rst asserted asynchronously mid-SERVICE -> busy, intrOut, retiOut, ack all 0 immediately. gie=0, so no entry after release even if irq is high until gie is rewritten.

Source files
------------

// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller sequencing the PC's intr/reti controls.
// Requests are latched, masked, gated by a global enable and resolved by fixed
// priority (bit 0 highest). Entry happens only at an instruction boundary with
// no jump pending, and only one level of service is allowed at a time.
// Optional build macro INTC_LEVEL_EN: level-sensitive sources (pending = irq)
// instead of the default rising-edge latch.
module interrupt_controller #(
   parameter int unsigned NUM_SRC    = 4,
   parameter logic [15:0] VEC_BASE   = 16'h0002,
   parameter logic [15:0] VEC_STRIDE = 16'h0002
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq,
   input  logic               cfgWe,
   input  logic [NUM_SRC:0]   cfgData,
   input  logic               instrDone,
   input  logic               jmpPending,
   input  logic               retiIn,
   output logic               intrOut,
   output logic               retiOut,
   output logic [15:0]        vecAddr,
   output logic [3:0]         activeId,
   output logic               busy,
   output logic [NUM_SRC-1:0] ack,
   output logic [NUM_SRC:0]   cfgOut
);

   localparam int unsigned ID_W   = 4;
   localparam int unsigned ADDR_W = 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ENTER   = 2'd1,
      S_SERVICE = 2'd2,
      S_EXIT    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                holdoff_q, holdoff_d;
   logic                gie_q, gie_d;
   logic [NUM_SRC-1:0]  mask_q, mask_d;
   logic                intr_q, intr_d;
   logic                reti_q, reti_d;
   logic                busy_q, busy_d;
   logic [NUM_SRC-1:0]  ack_q, ack_d;
   logic [ADDR_W-1:0]   vec_q, vec_d;
   logic [ID_W-1:0]     id_q, id_d;

   logic [NUM_SRC-1:0]  pend;
   logic [NUM_SRC-1:0]  cand;
   logic [ID_W-1:0]     sel_id;
   logic [NUM_SRC-1:0]  sel_hot;
   logic                accept;

`ifdef INTC_LEVEL_EN
   // Level-sensitive sources: the request line itself is the pending state.
   always_comb begin
      pend = irq;
   end
`else
   logic [NUM_SRC-1:0]  pending_q, pending_d;
   logic [NUM_SRC-1:0]  irq_prev_q;

   // Rising-edge latch; a new edge wins over the acceptance clear.
   always_comb begin
      pending_d = pending_q;
      if (accept) begin
         pending_d = pending_q & ~sel_hot;
      end
      pending_d = pending_d | (irq & ~irq_prev_q);
      pend      = pending_q;
   end

   // Pending bits and previous irq sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q  <= '0;
         irq_prev_q <= '0;
      end else begin
         pending_q  <= pending_d;
         irq_prev_q <= irq;
      end
   end
`endif

   // Fixed-priority pick: lowest enabled pending index wins.
   always_comb begin
      cand    = pend & mask_q;
      sel_id  = '0;
      sel_hot = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel_id     = ID_W'(i);
            sel_hot    = '0;
            sel_hot[i] = 1'b1;
         end
      end
   end

   // Entry only from IDLE, at an instruction boundary, with no jump and no holdoff.
   always_comb begin
      accept = (state_q == S_IDLE) && gie_q && (cand != '0) &&
               instrDone && !jmpPending && !holdoff_q;
   end

   // Next-state, configuration and registered-output decode.
   always_comb begin
      state_d   = state_q;
      holdoff_d = holdoff_q;
      gie_d     = gie_q;
      mask_d    = mask_q;
      intr_d    = 1'b0;
      reti_d    = 1'b0;
      ack_d     = '0;
      vec_d     = vec_q;
      id_d      = id_q;

      if (cfgWe) begin
         {gie_d, mask_d} = cfgData;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_ENTER;
               intr_d  = 1'b1;
               ack_d   = sel_hot;
               id_d    = sel_id;
               vec_d   = ADDR_W'(VEC_BASE + ADDR_W'(sel_id) * VEC_STRIDE);
            end
            if (holdoff_q && instrDone) begin
               holdoff_d = 1'b0;
            end
         end
         S_ENTER: begin
            state_d = S_SERVICE;
         end
         S_SERVICE: begin
            if (retiIn) begin
               state_d = S_EXIT;
               reti_d  = 1'b1;
            end
         end
         S_EXIT: begin
            state_d   = S_IDLE;
            holdoff_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_ENTER) || (state_d == S_SERVICE);
   end

   // State, configuration and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         holdoff_q <= 1'b0;
         gie_q     <= 1'b0;
         mask_q    <= '0;
         intr_q    <= 1'b0;
         reti_q    <= 1'b0;
         busy_q    <= 1'b0;
         ack_q     <= '0;
         vec_q     <= '0;
         id_q      <= '0;
      end else begin
         state_q   <= state_d;
         holdoff_q <= holdoff_d;
         gie_q     <= gie_d;
         mask_q    <= mask_d;
         intr_q    <= intr_d;
         reti_q    <= reti_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         vec_q     <= vec_d;
         id_q      <= id_d;
      end
   end

   assign intrOut  = intr_q;
   assign retiOut  = reti_q;
   assign vecAddr  = vec_q;
   assign activeId = id_q;
   assign busy     = busy_q;
   assign ack      = ack_q;
   assign cfgOut   = {gie_q, mask_q};

endmodule
